// File: rtl/alu_pkg.sv
// Shared encodings for the ALU/multiply/divide block: alu_op, funct, FSM states, internal ops.
package alu_pkg;

    // alu_op encoding
    localparam logic [1:0] AluOpAdd   = 2'd0;
    localparam logic [1:0] AluOpAnd   = 2'd1;
    localparam logic [1:0] AluOpFunct = 2'd2;
    localparam logic [1:0] AluOpOr    = 2'd3;

    // MIPS R-type funct codes
    localparam logic [5:0] FnSll   = 6'd0;
    localparam logic [5:0] FnSrl   = 6'd2;
    localparam logic [5:0] FnSra   = 6'd3;
    localparam logic [5:0] FnMfhi  = 6'd16;
    localparam logic [5:0] FnMflo  = 6'd18;
    localparam logic [5:0] FnMult  = 6'd24;
    localparam logic [5:0] FnMultu = 6'd25;
    localparam logic [5:0] FnDiv   = 6'd26;
    localparam logic [5:0] FnDivu  = 6'd27;
    localparam logic [5:0] FnAdd   = 6'd32;
    localparam logic [5:0] FnAddu  = 6'd33;
    localparam logic [5:0] FnSub   = 6'd34;
    localparam logic [5:0] FnSubu  = 6'd35;
    localparam logic [5:0] FnAnd   = 6'd36;
    localparam logic [5:0] FnOr    = 6'd37;
    localparam logic [5:0] FnXor   = 6'd38;
    localparam logic [5:0] FnNor   = 6'd39;
    localparam logic [5:0] FnSlt   = 6'd42;
    localparam logic [5:0] FnSltu  = 6'd43;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StMul  = 2'd1,
        StDiv  = 2'd2,
        StFin  = 2'd3
    } state_e;

    typedef enum logic [4:0] {
        OpNone, OpAdd, OpAddu, OpSub, OpSubu, OpAnd, OpOr, OpXor, OpNor,
        OpSlt, OpSltu, OpSll, OpSrl, OpSra, OpMfhi, OpMflo,
        OpMult, OpMultu, OpDiv, OpDivu
    } op_e;

    function automatic logic op_is_mul(input op_e op);
        return (op == OpMult) || (op == OpMultu);
    endfunction

    function automatic logic op_is_div(input op_e op);
        return (op == OpDiv) || (op == OpDivu);
    endfunction

endpackage

// File: rtl/alu_decode.sv
// Combinational decoder: alu_op/funct to internal op code.
module alu_decode
    import alu_pkg::*;
(
    input  logic [1:0] alu_op_i,
    input  logic [5:0] funct_i,
    output op_e        op_o
);

    // Immediate-style alu_op values bypass funct; addi never flags overflow so maps to ADDU.
    always_comb begin
        op_o = OpNone;
        case (alu_op_i)
            AluOpAdd: op_o = OpAddu;
            AluOpAnd: op_o = OpAnd;
            AluOpOr:  op_o = OpOr;
            default: begin
                unique case (funct_i)
                    FnSll:   op_o = OpSll;
                    FnSrl:   op_o = OpSrl;
                    FnSra:   op_o = OpSra;
                    FnMfhi:  op_o = OpMfhi;
                    FnMflo:  op_o = OpMflo;
                    FnMult:  op_o = OpMult;
                    FnMultu: op_o = OpMultu;
                    FnDiv:   op_o = OpDiv;
                    FnDivu:  op_o = OpDivu;
                    FnAdd:   op_o = OpAdd;
                    FnAddu:  op_o = OpAddu;
                    FnSub:   op_o = OpSub;
                    FnSubu:  op_o = OpSubu;
                    FnAnd:   op_o = OpAnd;
                    FnOr:    op_o = OpOr;
                    FnXor:   op_o = OpXor;
                    FnNor:   op_o = OpNor;
                    FnSlt:   op_o = OpSlt;
                    FnSltu:  op_o = OpSltu;
                    default: op_o = OpNone;
                endcase
            end
        endcase
    end

endmodule

// File: rtl/alu_muldiv.sv
// ALU with iterative shift-add multiplier and restoring divider sharing one accumulator.
module alu_muldiv
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       alu_op,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [SHW-1:0]   shamt,
    output logic [WIDTH-1:0] result,
    output logic             busy,
    output logic             done,
    output logic             overflow,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CntW = $clog2(WIDTH);

    op_e op;

    alu_decode u_decode (
        .alu_op_i (alu_op),
        .funct_i  (funct),
        .op_o     (op)
    );

    state_e                 state_q, state_d;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic [2*WIDTH-1:0]     acc_q, acc_d;     // mul: {partial, multiplier}; div: {rem, quotient}
    logic [WIDTH-1:0]       bmag_q, bmag_d;   // multiplicand or divisor magnitude
    logic [WIDTH-1:0]       a_q, a_d;         // raw dividend, returned in hi on divide by zero
    logic                   neg_q, neg_d;
    logic                   sgn_a_q, sgn_a_d;
    logic                   divz_q, divz_d;
    logic [WIDTH-1:0]       result_q, result_d;
    logic [WIDTH-1:0]       hi_q, hi_d;
    logic [WIDTH-1:0]       lo_q, lo_d;
    logic                   ovf_q, ovf_d;
    logic                   dz_q, dz_d;

    logic                   accept;
    logic [WIDTH-1:0]       sum, diff;
    logic [WIDTH-1:0]       sc_res;
    logic                   sc_ovf;
    logic                   is_signed;
    logic [WIDTH-1:0]       a_mag, b_mag;

    logic [WIDTH:0]         mul_sum;
    logic [2*WIDTH-1:0]     mul_next, mul_prod;
    logic [WIDTH:0]         div_sh, div_diff;
    logic                   div_ge;
    logic [2*WIDTH-1:0]     div_next;
    logic [WIDTH-1:0]       div_quo, div_rem;

    assign accept = start && ((state_q == StIdle) || (state_q == StFin));
    assign sum    = in_a + in_b;
    assign diff   = in_a - in_b;

    assign is_signed = (op == OpMult) || (op == OpDiv);
    assign a_mag     = (is_signed && in_a[WIDTH-1]) ? -in_a : in_a;
    assign b_mag     = (is_signed && in_b[WIDTH-1]) ? -in_b : in_b;

    // Single-cycle result and overflow for the currently presented op
    always_comb begin
        sc_res = '0;
        sc_ovf = 1'b0;
        case (op)
            OpAdd: begin
                sc_res = sum;
                sc_ovf = (in_a[WIDTH-1] == in_b[WIDTH-1]) && (sum[WIDTH-1] != in_a[WIDTH-1]);
            end
            OpAddu: sc_res = sum;
            OpSub: begin
                sc_res = diff;
                sc_ovf = (in_a[WIDTH-1] != in_b[WIDTH-1]) && (diff[WIDTH-1] != in_a[WIDTH-1]);
            end
            OpSubu: sc_res = diff;
            OpAnd:  sc_res = in_a & in_b;
            OpOr:   sc_res = in_a | in_b;
            OpXor:  sc_res = in_a ^ in_b;
            OpNor:  sc_res = ~(in_a | in_b);
            OpSlt:  sc_res = {{(WIDTH-1){1'b0}}, ($signed(in_a) < $signed(in_b))};
            OpSltu: sc_res = {{(WIDTH-1){1'b0}}, (in_a < in_b)};
            OpSll:  sc_res = in_b << shamt;
            OpSrl:  sc_res = in_b >> shamt;
            OpSra:  sc_res = $signed(in_b) >>> shamt;
            OpMfhi: sc_res = hi_q;
            OpMflo: sc_res = lo_q;
            default: begin
                sc_res = '0;
                sc_ovf = 1'b0;
            end
        endcase
    end

    // One multiply step (add-then-shift-right) and one restoring divide step, plus final fix-up
    always_comb begin
        mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? bmag_q : '0)};
        mul_next = {mul_sum, acc_q[WIDTH-1:1]};
        mul_prod = neg_q ? -mul_next : mul_next;

        div_sh   = acc_q[2*WIDTH-1:WIDTH-1];
        div_diff = div_sh - {1'b0, bmag_q};
        div_ge   = ~div_diff[WIDTH];
        div_next = {(div_ge ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0]), acc_q[WIDTH-2:0], div_ge};
        div_quo  = neg_q ? -div_next[WIDTH-1:0] : div_next[WIDTH-1:0];
        div_rem  = sgn_a_q ? -div_next[2*WIDTH-1:WIDTH] : div_next[2*WIDTH-1:WIDTH];
    end

    // Sequencer: accept in IDLE/FIN, iterate WIDTH steps in MUL/DIV, publish in FIN
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        bmag_d   = bmag_q;
        a_d      = a_q;
        neg_d    = neg_q;
        sgn_a_d  = sgn_a_q;
        divz_d   = divz_q;
        result_d = result_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        ovf_d    = ovf_q;
        dz_d     = dz_q;

        case (state_q)
            StIdle, StFin: begin
                if (accept) begin
                    if (op_is_mul(op) || op_is_div(op)) begin
                        cnt_d   = '0;
                        neg_d   = is_signed && (in_a[WIDTH-1] ^ in_b[WIDTH-1]);
                        sgn_a_d = is_signed && in_a[WIDTH-1];
                        divz_d  = (in_b == '0);
                        a_d     = in_a;
                        if (op_is_mul(op)) begin
                            state_d = StMul;
                            acc_d   = {{WIDTH{1'b0}}, b_mag};
                            bmag_d  = a_mag;
                        end else begin
                            state_d = StDiv;
                            acc_d   = {{WIDTH{1'b0}}, a_mag};
                            bmag_d  = b_mag;
                        end
                    end else begin
                        state_d  = StFin;
                        result_d = sc_res;
                        ovf_d    = sc_ovf;
                        dz_d     = 1'b0;
                    end
                end else begin
                    state_d = StIdle;
                end
            end
            StMul: begin
                acc_d = mul_next;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CntW'(WIDTH - 1)) begin
                    state_d  = StFin;
                    hi_d     = mul_prod[2*WIDTH-1:WIDTH];
                    lo_d     = mul_prod[WIDTH-1:0];
                    result_d = mul_prod[WIDTH-1:0];
                    ovf_d    = 1'b0;
                    dz_d     = 1'b0;
                end
            end
            StDiv: begin
                acc_d = div_next;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CntW'(WIDTH - 1)) begin
                    state_d = StFin;
                    ovf_d   = 1'b0;
                    dz_d    = divz_q;
                    if (divz_q) begin
                        hi_d     = a_q;
                        lo_d     = '1;
                        result_d = '1;
                    end else begin
                        hi_d     = div_rem;
                        lo_d     = div_quo;
                        result_d = div_quo;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers, asynchronously cleared
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            acc_q    <= '0;
            bmag_q   <= '0;
            a_q      <= '0;
            neg_q    <= 1'b0;
            sgn_a_q  <= 1'b0;
            divz_q   <= 1'b0;
            result_q <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            ovf_q    <= 1'b0;
            dz_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            bmag_q   <= bmag_d;
            a_q      <= a_d;
            neg_q    <= neg_d;
            sgn_a_q  <= sgn_a_d;
            divz_q   <= divz_d;
            result_q <= result_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            ovf_q    <= ovf_d;
            dz_q     <= dz_d;
        end
    end

    assign busy     = (state_q == StMul) || (state_q == StDiv);
    assign done     = (state_q == StFin);
    assign result   = result_q;
    assign overflow = ovf_q;
    assign div_zero = dz_q;
    assign hi       = hi_q;
    assign lo       = lo_q;

endmodule

// File: tb/tb_alu_muldiv.sv
// Directed self-checking bench for alu_muldiv at WIDTH=32.
module tb_alu_muldiv;

    localparam logic [1:0] OP_ADDI = 2'd0, OP_ANDI = 2'd1, OP_R = 2'd2, OP_ORI = 2'd3;
    localparam logic [5:0] F_SLL = 6'd0, F_SRL = 6'd2, F_SRA = 6'd3, F_MFHI = 6'd16,
                           F_MFLO = 6'd18, F_MULT = 6'd24, F_MULTU = 6'd25, F_DIV = 6'd26,
                           F_DIVU = 6'd27, F_ADD = 6'd32, F_ADDU = 6'd33, F_SUB = 6'd34,
                           F_XOR = 6'd38, F_NOR = 6'd39, F_SLT = 6'd42, F_SLTU = 6'd43;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  alu_op = 2'd0;
    logic [5:0]  funct = 6'd0;
    logic [31:0] in_a = '0, in_b = '0;
    logic [4:0]  shamt = '0;
    logic [31:0] result, hi, lo;
    logic        busy, done, overflow, div_zero;

    int n_vec = 0;
    int n_err = 0;

    alu_muldiv #(.WIDTH(32), .SHW(5)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .alu_op   (alu_op),
        .funct    (funct),
        .in_a     (in_a),
        .in_b     (in_b),
        .shamt    (shamt),
        .result   (result),
        .busy     (busy),
        .done     (done),
        .overflow (overflow),
        .div_zero (div_zero),
        .hi       (hi),
        .lo       (lo)
    );

    always #5 clk = ~clk;

    // Present one request for one edge; returns #1 after the acceptance edge.
    task automatic issue(input logic [1:0] op, input logic [5:0] fn, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] sh);
        alu_op = op; funct = fn; in_a = a; in_b = b; shamt = sh; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    // Bounded wait; cyc counts cycles since acceptance (1 on entry).
    task automatic wait_done(output int cyc);
        cyc = 1;
        while (!done && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic test_reset();
        n_vec++;
        if ({result, hi, lo, busy, done, overflow, div_zero} !== 100'd0) begin
            n_err++; $display("FAIL reset_outputs got %h want 0",
                              {result, hi, lo, busy, done, overflow, div_zero});
        end
        @(posedge clk); #1; rst = 1'b0; tick();
    endtask

    task automatic test_add();
        issue(OP_R, F_ADD, 32'h7FFF_FFFF, 32'h1, 5'd0);
        n_vec++; if (done !== 1'b1) begin n_err++; $display("FAIL add_done got %b want 1", done); end
        n_vec++; if (result !== 32'h8000_0000) begin n_err++; $display("FAIL add_result got %h want 80000000", result); end
        n_vec++; if (overflow !== 1'b1) begin n_err++; $display("FAIL add_ovf got %b want 1", overflow); end
        tick();
        n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL add_done_pulse got %b want 0", done); end
        issue(OP_R, F_ADDU, 32'h7FFF_FFFF, 32'h1, 5'd0);
        n_vec++; if ({result, overflow} !== {32'h8000_0000, 1'b0}) begin n_err++; $display("FAIL addu got %h/%b want 80000000/0", result, overflow); end
        issue(OP_R, F_SUB, 32'h8000_0000, 32'h1, 5'd0);
        n_vec++; if ({result, overflow} !== {32'h7FFF_FFFF, 1'b1}) begin n_err++; $display("FAIL sub_ovf got %h/%b want 7fffffff/1", result, overflow); end
        issue(OP_ADDI, 6'd0, 32'h7FFF_FFFF, 32'h1, 5'd0);
        n_vec++; if ({result, overflow} !== {32'h8000_0000, 1'b0}) begin n_err++; $display("FAIL addi got %h/%b want 80000000/0", result, overflow); end
        tick();
    endtask

    task automatic test_logic();
        issue(OP_ANDI, 6'd0, 32'hF0F0_1234, 32'h0FF0_FF00, 5'd0);
        n_vec++; if (result !== 32'h00F0_1200) begin n_err++; $display("FAIL andi got %h want 00f01200", result); end
        issue(OP_ORI, 6'd0, 32'hF000_0001, 32'h0000_0F00, 5'd0);
        n_vec++; if (result !== 32'hF000_0F01) begin n_err++; $display("FAIL ori got %h want f0000f01", result); end
        issue(OP_R, F_XOR, 32'hFFFF_0000, 32'h0F0F_0F0F, 5'd0);
        n_vec++; if (result !== 32'hF0F0_0F0F) begin n_err++; $display("FAIL xor got %h want f0f00f0f", result); end
        issue(OP_R, F_NOR, 32'hFFFF_0000, 32'h0000_00FF, 5'd0);
        n_vec++; if (result !== 32'h0000_FF00) begin n_err++; $display("FAIL nor got %h want 0000ff00", result); end
        tick();
    endtask

    // Shift operand presented on both inputs so either operand convention is accepted.
    task automatic test_shift_cmp();
        issue(OP_R, F_SRA, 32'h8000_0000, 32'h8000_0000, 5'd4);
        n_vec++; if (result !== 32'hF800_0000) begin n_err++; $display("FAIL sra got %h want f8000000", result); end
        issue(OP_R, F_SRL, 32'h8000_0000, 32'h8000_0000, 5'd4);
        n_vec++; if (result !== 32'h0800_0000) begin n_err++; $display("FAIL srl got %h want 08000000", result); end
        issue(OP_R, F_SLL, 32'h0000_0003, 32'h0000_0003, 5'd31);
        n_vec++; if (result !== 32'h8000_0000) begin n_err++; $display("FAIL sll got %h want 80000000", result); end
        issue(OP_R, F_SLT, 32'hFFFF_FFFF, 32'h1, 5'd0);
        n_vec++; if (result !== 32'h1) begin n_err++; $display("FAIL slt got %h want 1", result); end
        issue(OP_R, F_SLTU, 32'hFFFF_FFFF, 32'h1, 5'd0);
        n_vec++; if (result !== 32'h0) begin n_err++; $display("FAIL sltu got %h want 0", result); end
        issue(OP_R, 6'd63, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 5'd3);
        n_vec++; if ({done, result, overflow, div_zero} !== {1'b1, 32'h0, 1'b0, 1'b0}) begin n_err++; $display("FAIL funct63 got %b/%h/%b/%b want 1/0/0/0", done, result, overflow, div_zero); end
        tick();
    endtask

    task automatic test_mult();
        int cyc;
        issue(OP_R, F_MULT, 32'hFFFF_FFFD, 32'd5, 5'd0);
        n_vec++; if ({busy, done} !== 2'b10) begin n_err++; $display("FAIL mult_busy got %b want 10", {busy, done}); end
        wait_done(cyc);
        n_vec++; if (cyc !== 33) begin n_err++; $display("FAIL mult_latency got %0d want 33", cyc); end
        n_vec++; if ({hi, lo, result} !== {32'hFFFF_FFFF, 32'hFFFF_FFF1, 32'hFFFF_FFF1}) begin n_err++; $display("FAIL mult got %h/%h/%h want ffffffff/fffffff1/fffffff1", hi, lo, result); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL mult_fin_busy got %b want 0", busy); end
        tick();
        issue(OP_R, F_MULTU, 32'hFFFF_FFFF, 32'd2, 5'd0);
        wait_done(cyc);
        n_vec++; if ({hi, lo, cyc} !== {32'h1, 32'hFFFF_FFFE, 32'd33}) begin n_err++; $display("FAIL multu got %h/%h/%0d want 1/fffffffe/33", hi, lo, cyc); end
        issue(OP_R, F_MFHI, 32'h0, 32'h0, 5'd0);
        n_vec++; if ({done, result} !== {1'b1, 32'h1}) begin n_err++; $display("FAIL mfhi got %b/%h want 1/1", done, result); end
        tick();
    endtask

    task automatic test_div();
        int cyc;
        issue(OP_R, F_DIV, 32'hFFFF_FFF9, 32'd2, 5'd0);
        wait_done(cyc);
        n_vec++; if ({lo, hi, result, div_zero, cyc} !== {32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 32'd33}) begin n_err++; $display("FAIL div got %h/%h/%h/%b/%0d want fffffffd/ffffffff/fffffffd/0/33", lo, hi, result, div_zero, cyc); end
        tick();
        issue(OP_R, F_DIVU, 32'd7, 32'd0, 5'd0);
        wait_done(cyc);
        n_vec++; if ({div_zero, lo, hi, cyc} !== {1'b1, 32'hFFFF_FFFF, 32'd7, 32'd33}) begin n_err++; $display("FAIL divu_zero got %b/%h/%h/%0d want 1/ffffffff/7/33", div_zero, lo, hi, cyc); end
        tick();
        issue(OP_R, F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0);
        wait_done(cyc);
        n_vec++; if ({lo, hi, div_zero, overflow} !== {32'h8000_0000, 32'h0, 1'b0, 1'b0}) begin n_err++; $display("FAIL div_minneg got %h/%h/%b/%b want 80000000/0/0/0", lo, hi, div_zero, overflow); end
        tick();
    endtask

    task automatic test_back_to_back();
        int cyc;
        int ndone;
        issue(OP_R, F_DIV, 32'd100, 32'd7, 5'd0);
        cyc = 1;
        ndone = 0;
        // Hammer start with a MULT every busy cycle; none may be taken.
        while (!done && cyc < 100) begin
            alu_op = OP_R; funct = F_MULT; in_a = 32'd3; in_b = 32'd3; start = 1'b1;
            @(posedge clk); #1;
            cyc++;
        end
        n_vec++; if (cyc !== 33) begin n_err++; $display("FAIL b2b_latency got %0d want 33", cyc); end
        n_vec++; if ({lo, hi, result} !== {32'd14, 32'd2, 32'd14}) begin n_err++; $display("FAIL b2b_div got %h/%h/%h want e/2/e", lo, hi, result); end
        funct = F_MFLO; in_a = 32'd0; in_b = 32'd0;
        @(posedge clk); #1;
        start = 1'b0;
        n_vec++; if ({done, busy, result} !== {1'b1, 1'b0, 32'd14}) begin n_err++; $display("FAIL b2b_mflo got %b/%b/%h want 1/0/e", done, busy, result); end
        for (int i = 0; i < 5; i++) begin
            if (done) ndone++;
            tick();
        end
        n_vec++; if ({ndone, hi, lo} !== {32'd1, 32'd2, 32'd14}) begin n_err++; $display("FAIL b2b_after got %0d/%h/%h want 1/2/e", ndone, hi, lo); end
        issue(OP_R, F_ADD, 32'd10, 32'd20, 5'd0);
        alu_op = OP_R; funct = F_SUB; in_a = 32'd5; in_b = 32'd9; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n_vec++; if ({done, result} !== {1'b1, 32'hFFFF_FFFC}) begin n_err++; $display("FAIL b2b_single got %b/%h want 1/fffffffc", done, result); end
        tick();
    endtask

    task automatic test_reset_abort();
        int ndone;
        ndone = 0;
        issue(OP_R, F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0);
        for (int i = 0; i < 9; i++) tick();
        n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL abort_pre_busy got %b want 1", busy); end
        rst = 1'b1;
        #1;
        n_vec++; if ({result, hi, lo, busy, done, overflow, div_zero} !== 100'd0) begin n_err++; $display("FAIL abort_async got %h want 0", {result, hi, lo, busy, done, overflow, div_zero}); end
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (done) ndone++;
            tick();
        end
        n_vec++; if ({ndone, hi, lo, busy} !== {32'd0, 32'd0, 32'd0, 1'b0}) begin n_err++; $display("FAIL abort_after got %0d/%h/%h/%b want 0/0/0/0", ndone, hi, lo, busy); end
    endtask

    initial begin
        #1;
        test_reset();
        test_add();
        test_logic();
        test_shift_cmp();
        test_mult();
        test_div();
        test_back_to_back();
        test_reset_abort();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got running want finished");
        $fatal(1);
    end

endmodule
